// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad event scheduler: button indices,
// the event record and the drain state type.
package gamepad_pkg;

   localparam int NUM_BTN = 12;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   localparam logic [NUM_BTN-1:0] DPAD_MASK = 12'h0F0;

   // One button event as offered to the game logic.
   typedef struct packed {
      logic       player;
      logic [3:0] button;
      logic       rpt;
   } evt_t;

   typedef enum logic {
      ST_IDLE,
      ST_OFFER
   } drain_state_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [3:0] lowestIndex(input logic [NUM_BTN-1:0] v);
      lowestIndex = 4'd0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (v[i]) lowestIndex = 4'(i);
      end
   endfunction

endpackage

// File: rtl/gamepad_event_scheduler_pad_repeat_timer.sv
// Per-pad auto-repeat timer. Counts frames while the same set of
// repeat-eligible buttons stays held and fires a repeat hit for all of
// them on reaching the delay, then re-arms for the shorter period.
module pad_repeat_timer
   import gamepad_pkg::*;
#(
   parameter int                 REPEAT_DELAY  = 20,
   parameter int                 REPEAT_PERIOD = 4,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK   = DPAD_MASK
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_tick,
   input  logic [NUM_BTN-1:0] i_snap,
   input  logic [NUM_BTN-1:0] i_prev,
   output logic [NUM_BTN-1:0] o_hit
);

   logic [5:0]         r_cnt;
   logic [5:0]         w_cntInc;
   logic [NUM_BTN-1:0] w_held;
   logic [NUM_BTN-1:0] w_heldPrev;
   logic               w_stable;
   logic               w_fire;

   assign w_held     = i_snap & REPEAT_MASK;
   assign w_heldPrev = i_prev & REPEAT_MASK;
   assign w_stable   = (w_held != '0) && (w_held == w_heldPrev);
   assign w_cntInc   = r_cnt + 6'd1;
   assign w_fire     = w_stable && (w_cntInc == 6'(REPEAT_DELAY));
   assign o_hit      = (i_tick && w_fire) ? w_held : '0;

   // Frame counter: restarts whenever the held set changes or empties.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= 6'd0;
      end else if (i_tick) begin
         if (!w_stable) begin
            r_cnt <= 6'd0;
         end else if (w_fire) begin
            r_cnt <= 6'(REPEAT_DELAY - REPEAT_PERIOD);
         end else begin
            r_cnt <= w_cntInc;
         end
      end
   end

endmodule

// File: rtl/gamepad_event_scheduler.sv
// Turns two controllers' level button state into a stream of press and
// auto-repeat events, arbitrated round-robin onto one valid/ready port.
module gamepad_event_scheduler
   import gamepad_pkg::*;
#(
   parameter int                 REPEAT_DELAY  = 20,
   parameter int                 REPEAT_PERIOD = 4,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK   = DPAD_MASK
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_frame_tick,
   input  logic [NUM_BTN-1:0] i_pad0_btn,
   input  logic [NUM_BTN-1:0] i_pad1_btn,
   input  logic [1:0]         i_pad_present,
   output logic               o_evt_valid,
   input  logic               i_evt_ready,
   output logic               o_evt_player,
   output logic [3:0]         o_evt_button,
   output logic               o_evt_repeat,
   output logic               o_overrun
);

   localparam int PW = 2 * NUM_BTN;
   localparam logic [PW-1:0] ONE_HOT0 = PW'(1);

   logic [NUM_BTN-1:0] w_snap0, w_snap1;
   logic [NUM_BTN-1:0] w_hit0, w_hit1;
   logic [NUM_BTN-1:0] r_prev0, r_prev1;
   logic [PW-1:0]      r_pend, r_flag;
   logic [PW-1:0]      w_edge, w_hit, w_setPend, w_setFlag;
   logic [PW-1:0]      w_clrAbsent, w_popMask, w_pendKept;
   drain_state_t       r_state, w_stateNext;
   evt_t               r_evt;
   logic               r_rr, r_overrun;
   logic               w_load, w_anyPend, w_selPad;
   logic [3:0]         w_selIdx;
   logic [4:0]         w_popIdx;

   assign w_snap0     = i_pad_present[0] ? i_pad0_btn : '0;
   assign w_snap1     = i_pad_present[1] ? i_pad1_btn : '0;
   assign w_edge      = {w_snap1 & ~r_prev1, w_snap0 & ~r_prev0};
   assign w_hit       = {w_hit1, w_hit0};
   assign w_setPend   = i_frame_tick ? (w_edge | w_hit) : '0;
   assign w_setFlag   = w_setPend & w_hit & ~w_edge;
   assign w_clrAbsent = i_frame_tick ?
                        {{NUM_BTN{~i_pad_present[1]}}, {NUM_BTN{~i_pad_present[0]}}} : '0;
   assign w_pendKept  = r_pend & ~w_popMask & ~w_clrAbsent;

   pad_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_MASK  (REPEAT_MASK)
   ) u_timer0 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tick(i_frame_tick),
      .i_snap(w_snap0),
      .i_prev(r_prev0),
      .o_hit (w_hit0)
   );

   pad_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_MASK  (REPEAT_MASK)
   ) u_timer1 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tick(i_frame_tick),
      .i_snap(w_snap1),
      .i_prev(r_prev1),
      .o_hit (w_hit1)
   );

   // Drain decision: pick the priority pad (fall back to the other) and its lowest pending button.
   always_comb begin
      w_stateNext = r_state;
      w_popMask   = '0;
      w_anyPend   = |r_pend;
      w_load      = (r_state == ST_IDLE) || i_evt_ready;
      if (r_rr) begin
         w_selPad = (r_pend[PW-1:NUM_BTN] != '0);
      end else begin
         w_selPad = (r_pend[NUM_BTN-1:0] == '0);
      end
      w_selIdx = lowestIndex(w_selPad ? r_pend[PW-1:NUM_BTN] : r_pend[NUM_BTN-1:0]);
      w_popIdx = w_selPad ? (5'(w_selIdx) + 5'(NUM_BTN)) : 5'(w_selIdx);
      if (w_load) begin
         w_stateNext = w_anyPend ? ST_OFFER : ST_IDLE;
         if (w_anyPend) w_popMask = ONE_HOT0 << w_popIdx;
      end
   end

   // Drain state register; OFFER means the output register holds an event.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Output register and round-robin pointer, loaded only when a pop happens.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_evt <= '0;
         r_rr  <= 1'b0;
      end else if (w_load && w_anyPend) begin
         r_evt.player <= w_selPad;
         r_evt.button <= w_selIdx;
         r_evt.rpt    <= r_flag[w_popIdx];
         r_rr         <= ~w_selPad;
      end
   end

   // Pending set, repeat flags, previous snapshot and sticky overrun.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend    <= '0;
         r_flag    <= '0;
         r_prev0   <= '0;
         r_prev1   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_pend <= w_pendKept | w_setPend;
         r_flag <= (r_flag & ~w_setPend) | w_setFlag;
         if ((w_setPend & w_pendKept) != '0) r_overrun <= 1'b1;
         if (i_frame_tick) begin
            r_prev0 <= w_snap0;
            r_prev1 <= w_snap1;
         end
      end
   end

   assign o_evt_valid  = (r_state == ST_OFFER);
   assign o_evt_player = r_evt.player;
   assign o_evt_button = r_evt.button;
   assign o_evt_repeat = r_evt.rpt;
   assign o_overrun    = r_overrun;

endmodule
